rv32_hazard: RTL and testbench

Pipeline hazard controller for the five-stage RV32 core (fetch, decode, execute, mem, writeback). Generates per-stage stall/flush controls from load-use dependencies, taken branches, instruction/data bus wait states and fences, holds the pipeline in bubbles after reset, and counts stall cycles. The execute stage consumes `execute_stall_out`/`execute_flush_out` as its `stall_in`/`flush_in`.

---
 rtl/rv32_hazard_pkg.sv | 15 +
 rtl/rv32_hazard_load_use.sv | 18 +
 rtl/rv32_hazard.sv | 174 +++++++++++++++++
 tb/tb_rv32_hazard.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_hazard_pkg.sv
// Shared types and helpers for the RV32 pipeline hazard controller.
package rv32_hazard_pkg;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_RUN        = 2'd1,
    ST_FENCE      = 2'd2
  } hazard_state_e;

  // Width of the post-reset hold counter; never narrower than one bit.
  function automatic int hold_cnt_width(input int hold_cycles);
    return (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
  endfunction

endpackage

// File: rtl/rv32_hazard_load_use.sv
// Load-use dependency detector: a load in mem whose destination feeds the
// instruction waiting at the execute input.
module rv32_hazard_load_use (
  input  logic [4:0] execute_rs1_in,
  input  logic [4:0] execute_rs2_in,
  input  logic [4:0] mem_rd_in,
  input  logic       mem_rd_write_in,
  input  logic       mem_read_in,
  output logic       load_use_out
);

  // x0 is never a real producer, so it cannot create a dependency.
  always_comb begin
    load_use_out = mem_read_in & mem_rd_write_in & (|mem_rd_in) &
                   ((mem_rd_in == execute_rs1_in) | (mem_rd_in == execute_rs2_in));
  end

endmodule

// File: rtl/rv32_hazard.sv
// Pipeline hazard controller for the five-stage RV32 core: per-stage
// stall/flush generation, post-reset bubbles, fence handshake and a
// stall-cycle counter.
module rv32_hazard
  import rv32_hazard_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  execute_rs1_in,
  input  logic [4:0]  execute_rs2_in,
  input  logic [4:0]  mem_rd_in,
  input  logic        mem_rd_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_fence_in,
  input  logic        branch_taken_in,
  input  logic        imem_ready_in,
  input  logic        dmem_ready_in,
  input  logic        fence_done_in,
  output logic        pc_stall_out,
  output logic        fetch_stall_out,
  output logic        fetch_flush_out,
  output logic        decode_stall_out,
  output logic        decode_flush_out,
  output logic        execute_stall_out,
  output logic        execute_flush_out,
  output logic        mem_stall_out,
  output logic        mem_flush_out,
  output logic        fence_req_out,
  output logic [31:0] stall_cycles_out
);

  localparam int HOLD_W = hold_cnt_width(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  hazard_state_e     state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              discard, discard_next;
  logic              load_use;
  logic              dmem_wait;

  rv32_hazard_load_use u_load_use (
    .execute_rs1_in  (execute_rs1_in),
    .execute_rs2_in  (execute_rs2_in),
    .mem_rd_in       (mem_rd_in),
    .mem_rd_write_in (mem_rd_write_in),
    .mem_read_in     (mem_read_in),
    .load_use_out    (load_use)
  );

  assign dmem_wait = (mem_read_in | mem_write_in) & ~dmem_ready_in;

  // The hold counter counts elapsed bubble cycles up from zero, which is the
  // same as loading RESET_HOLD_CYCLES-1 and counting down to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RESET_HOLD;
      hold_cnt <= '0;
      discard  <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      discard  <= discard_next;
    end
  end

  // Next-state and prioritised stall/flush decode; flushes are only raised
  // for a stage whose stall is low.
  always_comb begin
    state_next        = state;
    hold_next         = hold_cnt;
    discard_next      = discard;
    pc_stall_out      = 1'b0;
    fetch_stall_out   = 1'b0;
    fetch_flush_out   = 1'b0;
    decode_stall_out  = 1'b0;
    decode_flush_out  = 1'b0;
    execute_stall_out = 1'b0;
    execute_flush_out = 1'b0;
    mem_stall_out     = 1'b0;
    mem_flush_out     = 1'b0;
    fence_req_out     = 1'b0;

    case (state)
      ST_RESET_HOLD: begin
        pc_stall_out      = 1'b1;
        fetch_flush_out   = 1'b1;
        decode_flush_out  = 1'b1;
        execute_flush_out = 1'b1;
        mem_flush_out     = 1'b1;
        discard_next      = 1'b0;
        if (hold_cnt == HOLD_LAST) begin
          state_next = ST_RUN;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end

      ST_RUN: begin
        // A word returning while discard is set is the stale wrong-path fetch.
        if (discard && imem_ready_in) begin
          discard_next = 1'b0;
        end
        if (dmem_wait) begin
          pc_stall_out      = 1'b1;
          fetch_stall_out   = 1'b1;
          decode_stall_out  = 1'b1;
          execute_stall_out = 1'b1;
          mem_flush_out     = 1'b1;
        end else if (mem_fence_in) begin
          pc_stall_out      = 1'b1;
          fetch_stall_out   = 1'b1;
          decode_stall_out  = 1'b1;
          execute_stall_out = 1'b1;
          mem_flush_out     = 1'b1;
          fence_req_out     = 1'b1;
          state_next        = ST_FENCE;
        end else if (branch_taken_in) begin
          fetch_flush_out   = 1'b1;
          decode_flush_out  = 1'b1;
          execute_flush_out = 1'b1;
          if (!imem_ready_in || discard) begin
            discard_next = 1'b1;
          end
        end else begin
          if (load_use) begin
            pc_stall_out      = 1'b1;
            fetch_stall_out   = 1'b1;
            decode_stall_out  = 1'b1;
            execute_flush_out = 1'b1;
          end
          if (!imem_ready_in || discard) begin
            pc_stall_out = 1'b1;
            if (!load_use) begin
              fetch_flush_out = 1'b1;
            end
          end
        end
      end

      ST_FENCE: begin
        if (discard && imem_ready_in) begin
          discard_next = 1'b0;
        end
        if (!fence_done_in) begin
          pc_stall_out      = 1'b1;
          fetch_stall_out   = 1'b1;
          decode_stall_out  = 1'b1;
          execute_stall_out = 1'b1;
          mem_flush_out     = 1'b1;
          fence_req_out     = 1'b1;
        end else begin
          state_next = ST_RUN;
        end
      end

      default: begin
        state_next = ST_RESET_HOLD;
      end
    endcase
  end

  // Stall-cycle counter: every held-PC cycle once the reset bubbles are over.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_out <= '0;
    end else if (pc_stall_out && (state != ST_RESET_HOLD)) begin
      stall_cycles_out <= stall_cycles_out + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv32_hazard.sv
// Self-checking bench for rv32_hazard: table of per-cycle vectors whose
// expected outputs are queued on drive and compared at the falling edge.
module tb_rv32_hazard;

  localparam int HOLD = 4;

  logic        clk;
  logic        reset_n;
  logic [4:0]  execute_rs1_in, execute_rs2_in, mem_rd_in;
  logic        mem_rd_write_in, mem_read_in, mem_write_in, mem_fence_in;
  logic        branch_taken_in, imem_ready_in, dmem_ready_in, fence_done_in;
  logic        pc_stall_out, fetch_stall_out, fetch_flush_out;
  logic        decode_stall_out, decode_flush_out;
  logic        execute_stall_out, execute_flush_out;
  logic        mem_stall_out, mem_flush_out, fence_req_out;
  logic [31:0] stall_cycles_out;
  logic [9:0]  dut_outs;

  rv32_hazard #(.RESET_HOLD_CYCLES(HOLD)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .execute_rs1_in    (execute_rs1_in),
    .execute_rs2_in    (execute_rs2_in),
    .mem_rd_in         (mem_rd_in),
    .mem_rd_write_in   (mem_rd_write_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .mem_fence_in      (mem_fence_in),
    .branch_taken_in   (branch_taken_in),
    .imem_ready_in     (imem_ready_in),
    .dmem_ready_in     (dmem_ready_in),
    .fence_done_in     (fence_done_in),
    .pc_stall_out      (pc_stall_out),
    .fetch_stall_out   (fetch_stall_out),
    .fetch_flush_out   (fetch_flush_out),
    .decode_stall_out  (decode_stall_out),
    .decode_flush_out  (decode_flush_out),
    .execute_stall_out (execute_stall_out),
    .execute_flush_out (execute_flush_out),
    .mem_stall_out     (mem_stall_out),
    .mem_flush_out     (mem_flush_out),
    .fence_req_out     (fence_req_out),
    .stall_cycles_out  (stall_cycles_out)
  );

  assign dut_outs = {pc_stall_out, fetch_stall_out, fetch_flush_out,
                     decode_stall_out, decode_flush_out,
                     execute_stall_out, execute_flush_out,
                     mem_stall_out, mem_flush_out, fence_req_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control field order: rd_write, read, write, fence, branch, imem_rdy, dmem_rdy, fence_done
  localparam logic [7:0] C_RDW   = 8'h80;
  localparam logic [7:0] C_RD    = 8'h40;
  localparam logic [7:0] C_WR    = 8'h20;
  localparam logic [7:0] C_FENCE = 8'h10;
  localparam logic [7:0] C_BR    = 8'h08;
  localparam logic [7:0] C_IRDY  = 8'h04;
  localparam logic [7:0] C_DRDY  = 8'h02;
  localparam logic [7:0] C_FDONE = 8'h01;
  localparam logic [7:0] IDLE    = C_IRDY | C_DRDY;

  // Output order: pc, fs, ff, ds, df, es, ef, ms, mf, fence_req
  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_HOLD  = 10'b1010101010;
  localparam logic [9:0] O_DMEM  = 10'b1101010010;
  localparam logic [9:0] O_FENCE = 10'b1101010011;
  localparam logic [9:0] O_BR    = 10'b0010101000;
  localparam logic [9:0] O_LU    = 10'b1101001000;
  localparam logic [9:0] O_IMEM  = 10'b1010000000;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [7:0] ctl;
    logic       in_hold;
    logic [9:0] outs;
  } vec_t;

  typedef struct {
    string       name;
    logic [9:0]  outs;
    int unsigned cnt;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned exp_cnt = 0;
  int          reset_at;

  function automatic vec_t mk(input string name, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [7:0] ctl, input logic in_hold,
                              input logic [9:0] outs);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.ctl = ctl; v.in_hold = in_hold; v.outs = outs;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    execute_rs1_in = v.rs1;
    execute_rs2_in = v.rs2;
    mem_rd_in      = v.rd;
    {mem_rd_write_in, mem_read_in, mem_write_in, mem_fence_in,
     branch_taken_in, imem_ready_in, dmem_ready_in, fence_done_in} = v.ctl;
  endtask

  task automatic check_output();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries required 1");
    end else begin
      e = sb.pop_front();
      if (dut_outs !== e.outs) begin
        errors++;
        $display("[TB] FAIL %s outs: got %b required %b", e.name, dut_outs, e.outs);
      end
      checks++;
      if (stall_cycles_out !== 32'(e.cnt)) begin
        errors++;
        $display("[TB] FAIL %s stall_cycles: got %0d required %0d", e.name, stall_cycles_out, e.cnt);
      end
    end
  endtask

  // Called just after a rising edge; occupies exactly one clock cycle.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    drive(v);
    e.name = v.name; e.outs = v.outs; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    check_output();
    if (!v.in_hold && v.outs[9]) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must flip to the hold pattern with no clock edge.
  task automatic do_reset(input string name);
    exp_t e;
    reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    e.name = name; e.outs = O_HOLD; e.cnt = 0;
    sb.push_back(e);
    check_output();
    drive(mk("idle", 5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Hold release
    vecs.push_back(mk("hold1",      5'd0, 5'd0, 5'd0, IDLE, 1'b1, O_HOLD));
    vecs.push_back(mk("hold2",      5'd0, 5'd0, 5'd0, IDLE, 1'b1, O_HOLD));
    vecs.push_back(mk("hold3",      5'd0, 5'd0, 5'd0, IDLE, 1'b1, O_HOLD));
    vecs.push_back(mk("hold4",      5'd0, 5'd0, 5'd0, IDLE, 1'b1, O_HOLD));
    vecs.push_back(mk("run_idle",   5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    // Load-use
    vecs.push_back(mk("lu_rs2",     5'd3, 5'd5, 5'd5, C_RDW | C_RD | IDLE, 1'b0, O_LU));
    vecs.push_back(mk("lu_after",   5'd3, 5'd5, 5'd0, IDLE, 1'b0, O_NONE));
    vecs.push_back(mk("lu_x0",      5'd0, 5'd0, 5'd0, C_RDW | C_RD | IDLE, 1'b0, O_NONE));
    vecs.push_back(mk("lu_nowrite", 5'd5, 5'd1, 5'd5, C_RD | IDLE, 1'b0, O_NONE));
    vecs.push_back(mk("lu_imemw",   5'd9, 5'd2, 5'd9, C_RDW | C_RD | C_DRDY, 1'b0, O_LU));
    vecs.push_back(mk("imem_wait",  5'd0, 5'd0, 5'd0, C_DRDY, 1'b0, O_IMEM));
    // Data-bus waits, including one that hides a load-use condition
    vecs.push_back(mk("st_wait",    5'd0, 5'd0, 5'd0, C_WR | C_IRDY, 1'b0, O_DMEM));
    vecs.push_back(mk("ld_wait1",   5'd7, 5'd1, 5'd7, C_RDW | C_RD, 1'b0, O_DMEM));
    vecs.push_back(mk("ld_wait2",   5'd7, 5'd1, 5'd7, C_RDW | C_RD | C_IRDY, 1'b0, O_DMEM));
    vecs.push_back(mk("ld_wait3",   5'd7, 5'd1, 5'd7, C_RDW | C_RD | C_IRDY, 1'b0, O_DMEM));
    vecs.push_back(mk("ld_done",    5'd1, 5'd2, 5'd7, C_RDW | C_RD | IDLE, 1'b0, O_NONE));
    // Taken branch with late instruction bus
    vecs.push_back(mk("br_late",    5'd0, 5'd0, 5'd0, C_BR | C_DRDY, 1'b0, O_BR));
    vecs.push_back(mk("br_wait",    5'd0, 5'd0, 5'd0, C_DRDY, 1'b0, O_IMEM));
    vecs.push_back(mk("br_drop",    5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_IMEM));
    vecs.push_back(mk("br_resume",  5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    vecs.push_back(mk("br_ready",   5'd0, 5'd0, 5'd0, C_BR | IDLE, 1'b0, O_BR));
    vecs.push_back(mk("br_rdy_nx",  5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    vecs.push_back(mk("br2_late",   5'd0, 5'd0, 5'd0, C_BR | C_DRDY, 1'b0, O_BR));
    vecs.push_back(mk("br2_again",  5'd0, 5'd0, 5'd0, C_BR | IDLE, 1'b0, O_BR));
    vecs.push_back(mk("br2_drop",   5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_IMEM));
    vecs.push_back(mk("br2_resume", 5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    // Fence released after five waiting cycles
    vecs.push_back(mk("fence_req",  5'd0, 5'd0, 5'd0, C_FENCE | IDLE, 1'b0, O_FENCE));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk($sformatf("fence_wait%0d", i), 5'd0, 5'd0, 5'd0, C_FENCE | IDLE, 1'b0, O_FENCE));
    vecs.push_back(mk("fence_done", 5'd0, 5'd0, 5'd0, C_FENCE | C_FDONE | IDLE, 1'b0, O_NONE));
    vecs.push_back(mk("fence_post", 5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    // Done already high when the fence arrives
    vecs.push_back(mk("fq_early",   5'd0, 5'd0, 5'd0, C_FENCE | C_FDONE | IDLE, 1'b0, O_FENCE));
    vecs.push_back(mk("fq_release", 5'd0, 5'd0, 5'd0, C_FENCE | C_FDONE | IDLE, 1'b0, O_NONE));
    vecs.push_back(mk("fq_post",    5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    // Data wait outranks a fence
    vecs.push_back(mk("fw_dwait",   5'd0, 5'd0, 5'd0, C_FENCE | C_WR | C_IRDY, 1'b0, O_DMEM));
    vecs.push_back(mk("fw_fence",   5'd0, 5'd0, 5'd0, C_FENCE | C_WR | IDLE, 1'b0, O_FENCE));
    vecs.push_back(mk("fw_done",    5'd0, 5'd0, 5'd0, C_FENCE | C_FDONE | IDLE, 1'b0, O_NONE));
    // Fence abandoned by a reset pulse
    vecs.push_back(mk("fr_req",     5'd0, 5'd0, 5'd0, C_FENCE | IDLE, 1'b0, O_FENCE));
    vecs.push_back(mk("fr_wait1",   5'd0, 5'd0, 5'd0, C_FENCE | IDLE, 1'b0, O_FENCE));
    vecs.push_back(mk("fr_wait2",   5'd0, 5'd0, 5'd0, C_FENCE | IDLE, 1'b0, O_FENCE));
    reset_at = vecs.size();
    vecs.push_back(mk("rh_hold1",   5'd0, 5'd0, 5'd0, IDLE, 1'b1, O_HOLD));
    vecs.push_back(mk("rh_hold2",   5'd0, 5'd0, 5'd0, IDLE, 1'b1, O_HOLD));
    vecs.push_back(mk("rh_hold3",   5'd0, 5'd0, 5'd0, IDLE, 1'b1, O_HOLD));
    vecs.push_back(mk("rh_hold4",   5'd0, 5'd0, 5'd0, IDLE, 1'b1, O_HOLD));
    vecs.push_back(mk("rh_run",     5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    vecs.push_back(mk("rh_lu_rs1",  5'd4, 5'd6, 5'd4, C_RDW | C_RD | IDLE, 1'b0, O_LU));
    vecs.push_back(mk("rh_end",     5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));

    reset_n = 1'b1;
    drive(mk("idle", 5'd0, 5'd0, 5'd0, IDLE, 1'b0, O_NONE));
    #2;
    $display("[TB] applying reset");
    do_reset("reset_assert");

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == reset_at) begin
        $display("[TB] pulsing reset mid-fence");
        do_reset("reset_mid_fence");
      end
      apply_stimulus(vecs[i]);
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
